// File: rtl/instr_fetch_queue_pkg.sv
// Shared constants and the queue entry layout for the instruction fetch queue.
package instr_fetch_queue_pkg;

  localparam int unsigned INSTR_W = 32;

  // Instruction presented to decode when the queue head is empty.
  localparam logic [INSTR_W-1:0] NOP = 32'h0000_0000;

  // Default first fetch address after reset.
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // One buffered fetch result: the address it came from and the word itself.
  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_queue_fifo_sync.sv
// Synchronous FIFO with register-array storage, a registered head (a pushed
// entry appears at the head on the following cycle) and a synchronous flush.
module instr_fetch_queue_fifo_sync #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic                     valid_o,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_q, wr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  // Full/empty guards keep the pointers consistent even if a caller misbehaves.
  assign do_push = push_i && (count_q != CW'(DEPTH)) && !flush_i;
  assign do_pop  = pop_i && (count_q != '0) && !flush_i;

  // Pointer and occupancy bookkeeping; flush returns to the empty state.
  // NOTE: sequential state uses <= so every register updates from pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Entry storage; contents are only observed through valid_o.
  // NOTE: the storage array has no reset; stale entries are never visible because occupancy is reset.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

  assign valid_o = (count_q != '0);
  assign data_o  = mem_q[rd_q];
  assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_queue.sv
// Decoupled instruction fetch: owns the fetch PC, issues one outstanding
// req/ack fetch at a time, buffers {pc, instr} pairs and serves decode.
module instr_fetch_queue
  import instr_fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                   clock_i,
  input  logic                   reset_ni,
  output logic                   mem_req_o,
  output logic [31:0]            mem_addr_o,
  input  logic                   mem_ack_i,
  input  logic [INSTR_W-1:0]     mem_rdata_i,
  input  logic                   redirect_i,
  input  logic [31:0]            redirect_pc_i,
  output logic                   instr_valid_o,
  output logic [INSTR_W-1:0]     instr_o,
  output logic [31:0]            instr_pc_o,
  input  logic                   instr_ready_i,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   addr_q, addr_d;
  logic          req_q, req_d;        // req_q doubles as the outstanding flag
  logic          discard_q, discard_d;
  logic          ack, push, pop;
  logic [CW-1:0] count, count_after;
  logic          head_valid;
  fetch_entry_t  head, wdata;
  logic          unused_rpc_lsb;

  assign unused_rpc_lsb = ^redirect_pc_i[1:0];

  assign ack   = req_q && mem_ack_i;
  // Redirect wins over both the returning word and a decode pop.
  assign push  = ack && !discard_q && !redirect_i;
  assign pop   = head_valid && instr_ready_i && !redirect_i;
  assign wdata = '{pc: addr_q, instr: mem_rdata_i};

  // Next fetch PC, discard flag and request issue decision.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    discard_d   = discard_q;
    req_d       = req_q;
    addr_d      = addr_q;
    count_after = count;

    if (redirect_i) begin
      fetch_pc_d  = {redirect_pc_i[31:2], 2'b00};
      count_after = '0;
    end else begin
      if (push) fetch_pc_d = addr_q + 32'd4;
      count_after = count + CW'(push) - CW'(pop);
    end

    // A redirect while a word is still in flight must drop that word later.
    if (ack)                     discard_d = 1'b0;
    else if (redirect_i && req_q) discard_d = 1'b1;

    if (req_q && !mem_ack_i) begin
      // Request must stay stable on the bus until the memory accepts it.
      req_d  = 1'b1;
      addr_d = addr_q;
    end else begin
      // Issue only if a queue slot is guaranteed for the returning word.
      req_d  = (count_after < CW'(DEPTH));
      addr_d = fetch_pc_d;
    end
  end

  // Fetch controller registers.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      fetch_pc_q <= RESET_PC & ~32'h3;
      addr_q     <= RESET_PC & ~32'h3;
      req_q      <= 1'b0;
      discard_q  <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      req_q      <= req_d;
      discard_q  <= discard_d;
    end
  end

  instr_fetch_queue_fifo_sync #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk_i   (clock_i),
    .rst_ni  (reset_ni),
    .flush_i (redirect_i),
    .push_i  (push),
    .data_i  (wdata),
    .pop_i   (pop),
    .valid_o (head_valid),
    .data_o  (head),
    .count_o (count)
  );

  assign mem_req_o     = req_q;
  assign mem_addr_o    = addr_q;
  assign instr_valid_o = head_valid;
  assign instr_o       = head_valid ? head.instr : NOP;
  assign instr_pc_o    = head_valid ? head.pc : 32'h0;
  assign count_o       = count;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue with a configurable-latency memory model
// that returns the request address as the instruction word.
module tb_instr_fetch_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req, mem_ack;
  logic [31:0] mem_addr, mem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid, instr_ready;
  logic [31:0] instr, instr_pc;
  logic [2:0]  count;

  int unsigned lat = 0;
  int unsigned wait_cnt = 0;
  int unsigned ack_cnt = 0;
  int unsigned ack_base;
  bit          full_viol = 1'b0;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clock_i       (clk),
    .reset_ni      (rst_n),
    .mem_req_o     (mem_req),
    .mem_addr_o    (mem_addr),
    .mem_ack_i     (mem_ack),
    .mem_rdata_i   (mem_rdata),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .instr_valid_o (instr_valid),
    .instr_o       (instr),
    .instr_pc_o    (instr_pc),
    .instr_ready_i (instr_ready),
    .count_o       (count)
  );

  // Memory model: ack once the request has waited lat cycles.
  assign mem_ack   = mem_req && (wait_cnt >= lat);
  assign mem_rdata = mem_addr;

  always @(posedge clk) begin
    if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
    else                     wait_cnt <= 0;
    if (mem_req && mem_ack) begin
      ack_cnt <= ack_cnt + 1;
      if (count == 3'd4) full_viol <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(input int max_cycles);
    int n = 0;
    while (!instr_valid && n < max_cycles) begin
      tick();
      n++;
    end
    check("wait_valid_timeout", 32'(instr_valid), 32'd1);
  endtask

  initial begin
    rst_n       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    instr_ready = 1'b1;
    lat         = 0;

    // Reset state
    tick();
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_valid",   32'(instr_valid), 32'd0);
    check("rst_instr",   instr, 32'h0);
    check("rst_pc",      instr_pc, 32'h0);
    check("rst_count",   32'(count), 32'd0);

    // 1: streaming with 0-wait memory and ready=1
    rst_n = 1'b1;
    tick();
    check("t1_req_first",  32'(mem_req), 32'd1);
    check("t1_addr_first", mem_addr, 32'h0);
    check("t1_not_valid",  32'(instr_valid), 32'd0);
    tick();
    for (int k = 0; k < 5; k++) begin
      check("t1_valid", 32'(instr_valid), 32'd1);
      check("t1_pc",    instr_pc, 32'(4 * k));
      check("t1_instr", instr, 32'(4 * k));
      check("t1_count", 32'(count), 32'd1);
      tick();
    end

    // 2: ready=0 fills the queue with exactly DEPTH words
    instr_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    ack_base = ack_cnt;
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) tick();
    check("t2_acks",    ack_cnt - ack_base, 32'd4);
    check("t2_req_low", 32'(mem_req), 32'd0);
    check("t2_count",   32'(count), 32'd4);
    check("t2_head",    instr_pc, 32'h0);
    instr_ready = 1'b1;
    tick();
    check("t2_req_back", 32'(mem_req), 32'd1);
    check("t2_addr",     mem_addr, 32'h10);
    check("t2_count3",   32'(count), 32'd3);
    for (int k = 1; k < 5; k++) begin
      check("t2_order", instr_pc, 32'(4 * k));
      tick();
    end

    // 3: 3-cycle memory, redirect to 0x103 while a request is waiting
    lat = 3;
    do_reset();
    tick();
    check("t3_req",   32'(mem_req), 32'd1);
    check("t3_addr0", mem_addr, 32'h0);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0103;
    tick();
    redirect = 1'b0;
    check("t3_hold_req", 32'(mem_req), 32'd1);
    check("t3_hold_a",   mem_addr, 32'h0);
    check("t3_count",    32'(count), 32'd0);
    tick();
    check("t3_hold_b", mem_addr, 32'h0);
    tick();
    check("t3_hold_c", mem_addr, 32'h0);
    tick();
    check("t3_new_addr", mem_addr, 32'h100);
    check("t3_dropped",  32'(instr_valid), 32'd0);
    wait_valid(10);
    check("t3_first_pc",    instr_pc, 32'h100);
    check("t3_first_instr", instr, 32'h100);

    // 4: redirect coincident with ack and a pop on a non-empty queue
    lat = 0;
    do_reset();
    tick();
    tick();
    check("t4_pre_count", 32'(count), 32'd1);
    check("t4_pre_ack",   32'(mem_ack), 32'd1);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0200;
    tick();
    redirect = 1'b0;
    check("t4_count0", 32'(count), 32'd0);
    check("t4_valid0", 32'(instr_valid), 32'd0);
    check("t4_instr0", instr, 32'h0);
    check("t4_pc0",    instr_pc, 32'h0);
    check("t4_addr",   mem_addr, 32'h200);
    tick();
    check("t4_valid", 32'(instr_valid), 32'd1);
    check("t4_pc",    instr_pc, 32'h200);

    // 5: redirect near the top of the address space, PC wraps to 0
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    tick();
    redirect = 1'b0;
    check("t5_addr_f8", mem_addr, 32'hFFFF_FFF8);
    tick();
    check("t5_addr_fc", mem_addr, 32'hFFFF_FFFC);
    check("t5_pc_f8",   instr_pc, 32'hFFFF_FFF8);
    tick();
    check("t5_addr_0", mem_addr, 32'h0);
    check("t5_pc_fc",  instr_pc, 32'hFFFF_FFFC);
    tick();
    check("t5_pc_0", instr_pc, 32'h0);
    check("t5_instr_0_valid", 32'(instr_valid), 32'd1);

    // 6: async reset with a request outstanding and three entries queued
    instr_ready = 1'b0;
    tick();
    tick();
    check("t6_count3", 32'(count), 32'd3);
    check("t6_req",    32'(mem_req), 32'd1);
    check("t6_addr",   mem_addr, 32'hC);
    lat = 3;
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_req_clr",   32'(mem_req), 32'd0);
    check("t6_valid_clr", 32'(instr_valid), 32'd0);
    check("t6_count_clr", 32'(count), 32'd0);
    check("t6_instr_clr", instr, 32'h0);
    check("t6_pc_clr",    instr_pc, 32'h0);
    tick();
    lat = 0;
    rst_n = 1'b1;
    tick();
    check("t6_req_again", 32'(mem_req), 32'd1);
    check("t6_addr_rst",  mem_addr, 32'h0);

    check("no_push_when_full", 32'(full_viol), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
